// File: rtl/ex_mem_pipe_if.sv
// ex_mem_pipe_if: one EX->MEM entry bus (valid/ready handshake plus payload).
//   valid, ready         handshake
//   alu                  ALU result, also the memory address
//   store_data           rs2 value for stores
//   pc                   instruction pc
//   rd, rd_we            destination register and its write enable
//   mem_read, mem_write  load / store
//   mem_size             funct3: [1:0] log2 bytes, [2] unsigned load
// The master modport produces an entry; the slave modport consumes it.
interface ex_mem_pipe_if #(
   parameter int XLEN = 64,
   parameter int REGW = 5
);
   logic            valid;
   logic            ready;
   logic [XLEN-1:0] alu;
   logic [XLEN-1:0] store_data;
   logic [XLEN-1:0] pc;
   logic [REGW-1:0] rd;
   logic            rd_we;
   logic            mem_read;
   logic            mem_write;
   logic [2:0]      mem_size;

   modport master (
      output valid, alu, store_data, pc, rd, rd_we, mem_read, mem_write, mem_size,
      input  ready
   );

   modport slave (
      input  valid, alu, store_data, pc, rd, rd_we, mem_read, mem_write, mem_size,
      output ready
   );
endinterface

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX->MEM pipeline stage.
//   Registers the ALU result and memory-control payload coming out of execute,
//   flags misaligned memory accesses, and drives a forwarding port from its
//   output register back to execute operand selection.
// Ports:
//   clk, rst     clock; synchronous active-high reset (wins over flush)
//   flush        drops every held entry and any entry accepted this cycle
//   ex           slave side of the entry bus (from execute)
//   mem          master side of the entry bus (to MEM)
//   misaligned   memory op address not aligned to its access size
//   fwd_valid    forwarding candidate present (non-load writer of rd)
//   fwd_rd       forwarded register index
//   fwd_data     forwarded value (ALU result)
// Build option:
//   EX_MEM_SKID_EN  defined -> two entries (main + skid), in_ready driven from
//                   a register so it no longer depends on mem.ready.
//                   undefined -> single register, in_ready combinational.
module ex_mem_pipe #(
   parameter int XLEN = 64,
   parameter int REGW = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   ex_mem_pipe_if.slave    ex,
   ex_mem_pipe_if.master   mem,
   output logic            misaligned,
   output logic            fwd_valid,
   output logic [REGW-1:0] fwd_rd,
   output logic [XLEN-1:0] fwd_data
);

   typedef struct packed {
      logic [XLEN-1:0] alu;
      logic [XLEN-1:0] store_data;
      logic [XLEN-1:0] pc;
      logic [REGW-1:0] rd;
      logic            rd_we;
      logic            mem_read;
      logic            mem_write;
      logic [2:0]      mem_size;
      logic            mis;
   } entry_t;

   entry_t cap;
   entry_t main_q;
   logic   main_vld;
   logic   in_fire;

   assign in_fire = ex.valid & ex.ready;

   // Entry as it will be stored. A write to x0 is dropped here so nothing
   // downstream (including forwarding) has to special-case rd == 0.
   always_comb begin
      cap            = '0;
      cap.alu        = ex.alu;
      cap.store_data = ex.store_data;
      cap.pc         = ex.pc;
      cap.rd         = ex.rd;
      cap.rd_we      = ex.rd_we & (ex.rd != '0);
      cap.mem_read   = ex.mem_read;
      cap.mem_write  = ex.mem_write;
      cap.mem_size   = ex.mem_size;
      cap.mis        = 1'b0;
      if (ex.mem_read | ex.mem_write) begin
         case (ex.mem_size[1:0])
            2'd0:    cap.mis = 1'b0;
            2'd1:    cap.mis = ex.alu[0];
            2'd2:    cap.mis = |ex.alu[1:0];
            default: cap.mis = |ex.alu[2:0];
         endcase
      end
   end

`ifdef EX_MEM_SKID_EN
   entry_t skid_q;
   logic   skid_vld;

   // Skid is only ever filled while main is stalled, so a full skid is the
   // one and only reason to refuse an entry.
   assign ex.ready = ~rst & ~skid_vld;

   always_ff @(posedge clk) begin
      if (rst) begin
         main_vld <= 1'b0;
         skid_vld <= 1'b0;
         main_q   <= '0;
         skid_q   <= '0;
      end else if (flush) begin
         main_vld <= 1'b0;
         skid_vld <= 1'b0;
      end else if (~main_vld | mem.ready) begin
         // Main is empty or leaving: the older skid entry goes first.
         if (skid_vld) begin
            main_q   <= skid_q;
            main_vld <= 1'b1;
            skid_vld <= 1'b0;
         end else if (in_fire) begin
            main_q   <= cap;
            main_vld <= 1'b1;
         end else begin
            main_vld <= 1'b0;
         end
      end else if (in_fire) begin
         skid_q   <= cap;
         skid_vld <= 1'b1;
      end
   end
`else
   logic out_fire;

   assign out_fire = main_vld & mem.ready;
   assign ex.ready = ~rst & (~main_vld | mem.ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         main_vld <= 1'b0;
         main_q   <= '0;
      end else if (flush) begin
         main_vld <= 1'b0;
      end else if (in_fire) begin
         // Covers simultaneous out-fire too: the new entry replaces the old.
         main_q   <= cap;
         main_vld <= 1'b1;
      end else if (out_fire) begin
         main_vld <= 1'b0;
      end
   end
`endif

   assign mem.valid      = main_vld;
   assign mem.alu        = main_q.alu;
   assign mem.store_data = main_q.store_data;
   assign mem.pc         = main_q.pc;
   assign mem.rd         = main_q.rd;
   assign mem.rd_we      = main_q.rd_we;
   assign mem.mem_read   = main_q.mem_read;
   assign mem.mem_write  = main_q.mem_write;
   assign mem.mem_size   = main_q.mem_size;
   assign misaligned     = main_q.mis;

   // Load data does not exist until MEM, so loads never forward from here.
   assign fwd_valid = main_vld & main_q.rd_we & ~main_q.mem_read;
   assign fwd_rd    = main_q.rd;
   assign fwd_data  = main_q.alu;

endmodule
